// File: rtl/pio_pkg.sv
// Shared constants for the debounced PIO: register map, edge-mode encodings,
// bus widths and the debounce counter sizing helper.
package pio_pkg;

   localparam int unsigned AVS_AW = 3;
   localparam int unsigned AVS_DW = 32;

   localparam logic [AVS_AW-1:0] ADDR_DATA_IN  = 3'd0;
   localparam logic [AVS_AW-1:0] ADDR_DATA_OUT = 3'd1;
   localparam logic [AVS_AW-1:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [AVS_AW-1:0] ADDR_EDGE_CAP = 3'd3;
   localparam logic [AVS_AW-1:0] ADDR_OUT_SET  = 3'd4;
   localparam logic [AVS_AW-1:0] ADDR_OUT_CLR  = 3'd5;

   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

   // Counter must hold 0..cycles without wrapping; never narrower than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles == 0) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/pio_debounce_irq_if.sv
// Avalon-MM slave bus bundle for the PIO register block.
interface pio_debounce_irq_if;
   import pio_pkg::*;

   logic [AVS_AW-1:0] avs_address;
   logic              avs_read;
   logic              avs_write;
   logic [AVS_DW-1:0] avs_writedata;
   logic [AVS_DW-1:0] avs_readdata;

   modport master (output avs_address, avs_read, avs_write, avs_writedata,
                   input  avs_readdata);
   modport slave  (input  avs_address, avs_read, avs_write, avs_writedata,
                   output avs_readdata);
endinterface

// File: rtl/pio_debounce_bit.sv
// One input pin: 2-flop synchroniser followed by a stability counter that only
// accepts a new level after DEBOUNCE_CYCLES consecutive differing cycles.
module pio_debounce_bit
   import pio_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter logic        RESET_VAL       = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic stable
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic stable_q, stable_d;

   always_comb begin
      sync1_d = pin;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= RESET_VAL;
         sync2_q  <= RESET_VAL;
         stable_q <= RESET_VAL;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
      end
   end

   if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_comb stable_d = sync2_q;
   end else begin : g_count
      localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      // Count while the synchronised level disagrees; accept on the last count.
      always_comb begin
         stable_d = stable_q;
         cnt_d    = '0;
         if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) stable_d = sync2_q;
            else                   cnt_d    = cnt_q + CW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (reset) cnt_q <= '0;
         else       cnt_q <= cnt_d;
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/pio_debounce_irq.sv
// Debounced edge-capturing input port plus set/clear output port behind one
// Avalon-MM slave, with a maskable level interrupt.
module pio_debounce_irq
   import pio_pkg::*;
#(
   parameter int unsigned           IN_WIDTH        = 2,
   parameter int unsigned           OUT_WIDTH       = 10,
   parameter int unsigned           DEBOUNCE_CYCLES = 50000,
   parameter int unsigned           EDGE_MODE       = 1,
   parameter logic [IN_WIDTH-1:0]   IN_RESET_VAL    = '1,
   parameter logic [OUT_WIDTH-1:0]  OUT_RESET_VAL   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   pio_debounce_irq_if.slave     avs,
   input  logic [IN_WIDTH-1:0]   pio_in,
   output logic [OUT_WIDTH-1:0]  pio_out,
   output logic                  irq
);

   logic [IN_WIDTH-1:0]  stable;
   logic [IN_WIDTH-1:0]  stable_prev_q, stable_prev_d;
   logic [IN_WIDTH-1:0]  edge_det_c;
   logic [IN_WIDTH-1:0]  edge_cap_q, edge_cap_d;
   logic [IN_WIDTH-1:0]  irq_mask_q, irq_mask_d;
   logic [OUT_WIDTH-1:0] pio_out_q, pio_out_d;
   logic [AVS_DW-1:0]    rdata_q, rdata_d;
   logic [AVS_DW-1:0]    wdata;
   logic                 unused_wdata;

   for (genvar i = 0; i < IN_WIDTH; i++) begin : g_in
      pio_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (IN_RESET_VAL[i])
      ) u_bit (
         .clk    (clk),
         .reset  (reset),
         .pin    (pio_in[i]),
         .stable (stable[i])
      );
   end

   assign wdata        = avs.avs_writedata;
   assign unused_wdata = ^wdata;

   // Edge seen while stable differs from last cycle's value.
   always_comb begin
      stable_prev_d = stable;
      if (EDGE_MODE == EDGE_RISE)      edge_det_c = stable & ~stable_prev_q;
      else if (EDGE_MODE == EDGE_FALL) edge_det_c = ~stable & stable_prev_q;
      else                             edge_det_c = stable ^ stable_prev_q;
   end

   // Register writes and read mux; a new edge always beats a W1C.
   always_comb begin
      pio_out_d  = pio_out_q;
      irq_mask_d = irq_mask_q;
      edge_cap_d = edge_cap_q | edge_det_c;
      rdata_d    = '0;

      if (avs.avs_write) begin
         case (avs.avs_address)
            ADDR_DATA_OUT: pio_out_d  = wdata[OUT_WIDTH-1:0];
            ADDR_IRQ_MASK: irq_mask_d = wdata[IN_WIDTH-1:0];
            ADDR_EDGE_CAP: edge_cap_d = (edge_cap_q & ~wdata[IN_WIDTH-1:0]) | edge_det_c;
            ADDR_OUT_SET:  pio_out_d  = pio_out_q | wdata[OUT_WIDTH-1:0];
            ADDR_OUT_CLR:  pio_out_d  = pio_out_q & ~wdata[OUT_WIDTH-1:0];
            default:       ;
         endcase
      end

      if (avs.avs_read) begin
         case (avs.avs_address)
            ADDR_DATA_IN:  rdata_d = AVS_DW'(stable);
            ADDR_DATA_OUT: rdata_d = AVS_DW'(pio_out_q);
            ADDR_IRQ_MASK: rdata_d = AVS_DW'(irq_mask_q);
            ADDR_EDGE_CAP: rdata_d = AVS_DW'(edge_cap_q);
            default:       rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stable_prev_q <= IN_RESET_VAL;
         edge_cap_q    <= '0;
         irq_mask_q    <= '0;
         pio_out_q     <= OUT_RESET_VAL;
         rdata_q       <= '0;
      end else begin
         stable_prev_q <= stable_prev_d;
         edge_cap_q    <= edge_cap_d;
         irq_mask_q    <= irq_mask_d;
         pio_out_q     <= pio_out_d;
         rdata_q       <= rdata_d;
      end
   end

   assign avs.avs_readdata = rdata_q;
   assign pio_out          = pio_out_q;
   assign irq              = |(edge_cap_q & irq_mask_q);

endmodule
